// File: rtl/scalar_core.sv
// scalar_core: single-issue 32-bit scalar execution core.
// One instruction is executed per clock. Architectural state is a GPR file
// and a status word. Results are visible only through status_out and illegal.
// Optional feature macro: SCALAR_MUL_EN enables opcode 0B (MUL, low 32 bits).
// This core has no FSM and no valid/ready handshake: instruction is consumed
// unconditionally on every rising edge while rst is low.
module scalar_core #(
    parameter int NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [31:0] status_out,
    output logic        illegal
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_SLL  = 6'h06;
    localparam logic [5:0] OP_SRL  = 6'h07;
    localparam logic [5:0] OP_SRA  = 6'h08;
    localparam logic [5:0] OP_SLT  = 6'h09;
    localparam logic [5:0] OP_SLTU = 6'h0A;
    localparam logic [5:0] OP_MUL  = 6'h0B;
    localparam logic [5:0] OP_ADDI = 6'h10;
    localparam logic [5:0] OP_ANDI = 6'h11;
    localparam logic [5:0] OP_ORI  = 6'h12;
    localparam logic [5:0] OP_XORI = 6'h13;
    localparam logic [5:0] OP_LUI  = 6'h14;

    // Instruction fields; rs2 and imm16 overlap, each op uses one or the other
    logic [5:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm16;

    assign op    = instruction[31:26];
    assign rd    = instruction[25:22];
    assign rs1   = instruction[21:18];
    assign rs2   = instruction[17:14];
    assign imm16 = instruction[15:0];

    // r0 is hardwired to zero, so storage exists only for r1 upward
    logic [31:0] regs [1:NUM_REGS-1];

    // Status word pieces
    logic [3:0]  flags;      // {V, C, N, Z}
    logic        sticky_ill;
    logic [7:0]  retired;
    logic [15:0] last_res;

    assign status_out = {last_res, retired, 3'b000, sticky_ill, flags};

    // Register indices beyond the implemented file make the instruction illegal
    logic rd_ok;
    logic rs1_ok;
    logic rs2_ok;

    assign rd_ok  = {1'b0, rd}  < 5'(NUM_REGS);
    assign rs1_ok = {1'b0, rs1} < 5'(NUM_REGS);
    assign rs2_ok = {1'b0, rs2} < 5'(NUM_REGS);

    // Operand read: values from before the current edge, r0 reads as zero
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    always_comb begin
        rs1_val = 32'h0;
        rs2_val = 32'h0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1 == 4'(i)) rs1_val = regs[i];
            if (rs2 == 4'(i)) rs2_val = regs[i];
        end
    end

    // Adder shared by ADD and ADDI; subtractor carries the borrow in bit 32
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] add_b;
    logic [32:0] add_full;
    logic [32:0] sub_full;

    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'h0, imm16};
    assign add_b    = (op == OP_ADDI) ? imm_sext : rs2_val;
    assign add_full = {1'b0, rs1_val} + {1'b0, add_b};
    assign sub_full = {1'b0, rs1_val} - {1'b0, rs2_val};

`ifdef SCALAR_MUL_EN
    logic [31:0] mul_lo;
    assign mul_lo = rs1_val * rs2_val;
`endif

    // Decode and execute: result, carry/overflow and which state gets updated
    logic [31:0] result;
    logic        res_c;
    logic        res_v;
    logic        op_known;
    logic        is_rtype;
    logic        upd_flags;
    logic        upd_result;
    logic        legal;

    always_comb begin
        result     = 32'h0;
        res_c      = 1'b0;
        res_v      = 1'b0;
        op_known   = 1'b1;
        is_rtype   = 1'b1;
        upd_flags  = 1'b1;
        upd_result = 1'b1;
        case (op)
            OP_NOP: begin
                upd_flags  = 1'b0;
                upd_result = 1'b0;
            end
            OP_ADD, OP_ADDI: begin
                is_rtype = (op == OP_ADD);
                result   = add_full[31:0];
                res_c    = add_full[32];
                res_v    = (rs1_val[31] == add_b[31]) && (add_full[31] != rs1_val[31]);
            end
            OP_SUB: begin
                result = sub_full[31:0];
                res_c  = ~sub_full[32];
                res_v  = (rs1_val[31] != rs2_val[31]) && (sub_full[31] != rs1_val[31]);
            end
            OP_AND:  result = rs1_val & rs2_val;
            OP_OR:   result = rs1_val | rs2_val;
            OP_XOR:  result = rs1_val ^ rs2_val;
            OP_SLL:  result = rs1_val << rs2_val[4:0];
            OP_SRL:  result = rs1_val >> rs2_val[4:0];
            OP_SRA:  result = $signed(rs1_val) >>> rs2_val[4:0];
            OP_SLT:  result = {31'h0, $signed(rs1_val) < $signed(rs2_val)};
            OP_SLTU: result = {31'h0, rs1_val < rs2_val};
`ifdef SCALAR_MUL_EN
            OP_MUL:  result = mul_lo;
`endif
            OP_ANDI: begin
                is_rtype = 1'b0;
                result   = rs1_val & imm_zext;
            end
            OP_ORI: begin
                is_rtype = 1'b0;
                result   = rs1_val | imm_zext;
            end
            OP_XORI: begin
                is_rtype = 1'b0;
                result   = rs1_val ^ imm_zext;
            end
            OP_LUI: begin
                is_rtype  = 1'b0;
                upd_flags = 1'b0;
                result    = {imm16, 16'h0};
            end
            default: begin
                op_known   = 1'b0;
                upd_flags  = 1'b0;
                upd_result = 1'b0;
            end
        endcase
        legal = op_known && rd_ok && rs1_ok && (!is_rtype || rs2_ok);
    end

    // Architectural state update; illegal instructions only touch the sticky bit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= 32'h0;
            flags      <= 4'h0;
            sticky_ill <= 1'b0;
            retired    <= 8'h0;
            last_res   <= 16'h0;
            illegal    <= 1'b0;
        end else begin
            illegal <= ~legal;
            if (legal) begin
                retired <= retired + 8'd1;
                if (upd_flags) begin
                    flags <= {res_v, res_c, result[31], (result == 32'h0)};
                end
                if (upd_result) begin
                    last_res <= result[15:0];
                    for (int i = 1; i < NUM_REGS; i++) begin
                        if (rd == 4'(i)) regs[i] <= result;
                    end
                end
            end else begin
                sticky_ill <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scalar_core.sv
// tb_scalar_core: directed vectors, random stimulus against a reference model,
// reset/wrap corner cases, and a reduced-register-file instance.
module tb_scalar_core;

`ifdef SCALAR_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] status_out;
    logic        illegal;
    logic [31:0] instruction8;
    logic [31:0] status_out8;
    logic        illegal8;

    int checks;
    int errors;

    scalar_core #(.NUM_REGS(16)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .status_out(status_out), .illegal(illegal)
    );

    scalar_core #(.NUM_REGS(8)) dut8 (
        .clk(clk), .rst(rst), .instruction(instruction8),
        .status_out(status_out8), .illegal(illegal8)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    logic        m_sticky;
    logic [7:0]  m_cnt;
    logic [15:0] m_res;
    logic        m_ill;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs1, input int rs2);
        return {op, 4'(rd), 4'(rs1), 4'(rs2), 14'h0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rd, input int rs1, input logic [15:0] imm);
        return {op, 4'(rd), 4'(rs1), 2'b00, imm};
    endfunction

    function automatic logic [31:0] m_status();
        return {m_res, m_cnt, 3'b000, m_sticky, m_flags};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_flags  = 4'h0;
        m_sticky = 1'b0;
        m_cnt    = 8'h0;
        m_res    = 16'h0;
        m_ill    = 1'b0;
    endtask

    // Architectural effect of one instruction on a 16-register core
    task automatic model_exec(input logic [31:0] ins);
        int          op;
        int          rd;
        int          rs1;
        int          rs2;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm_s;
        logic [31:0] imm_z;
        logic [31:0] res;
        longint      s;
        longint      u;
        int          sh;
        bit          known;
        bit          rtype;
        bit          c;
        bit          v;
        op    = int'(ins[31:26]);
        rd    = int'(ins[25:22]);
        rs1   = int'(ins[21:18]);
        rs2   = int'(ins[17:14]);
        a     = m_regs[rs1];
        b     = m_regs[rs2];
        imm_z = {16'h0, ins[15:0]};
        imm_s = {{16{ins[15]}}, ins[15:0]};
        sh    = int'(b % 32);
        rtype = (op <= 'h0B);
        known = (op <= 'h0A) || (op == 'h0B && MUL_ON) || (op >= 'h10 && op <= 'h14);
        // All indices fit in 16 registers, so legality is opcode-only here
        if (!known || !rtype && 0) begin
            m_sticky = 1'b1;
            m_ill    = 1'b1;
            return;
        end
        m_ill = 1'b0;
        m_cnt = m_cnt + 8'd1;
        if (op == 0) return;
        c = 0;
        v = 0;
        res = 0;
        case (op)
            'h01, 'h10: begin
                if (op == 'h10) b = imm_s;
                u   = longint'(a) + longint'(b);
                s   = longint'($signed(a)) + longint'($signed(b));
                res = u[31:0];
                c   = u >= 64'sh1_0000_0000;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            'h02: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                res = a - b;
                c   = a >= b;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            'h03: res = a & b;
            'h04: res = a | b;
            'h05: res = a ^ b;
            'h06: res = a << sh;
            'h07: res = a >> sh;
            'h08: res = a[31] ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
            'h09: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            'h0A: res = (a < b) ? 32'd1 : 32'd0;
            'h0B: begin
                u   = longint'(a) * longint'(b);
                res = u[31:0];
            end
            'h11: res = a & imm_z;
            'h12: res = a | imm_z;
            'h13: res = a ^ imm_z;
            'h14: res = {ins[15:0], 16'h0};
            default: res = 0;
        endcase
        if (op != 'h14) m_flags = {v, c, res[31], res == 0};
        m_res = res[15:0];
        if (rd != 0) m_regs[rd] = res;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Apply one instruction to the main core and compare against the model
    task automatic exec_chk(input logic [31:0] ins, input string nm);
        instruction = ins;
        @(posedge clk);
        #1;
        model_exec(ins);
        chk({nm, "_status"}, status_out, m_status());
        chk({nm, "_illegal"}, {31'h0, illegal}, {31'h0, m_ill});
    endtask

    // Two-clock reset with a live instruction present, which must be discarded
    task automatic do_reset();
        rst          = 1'b1;
        instruction  = enc_i(6'h10, 1, 0, 16'h1234);
        instruction8 = enc_i(6'h10, 1, 0, 16'h1234);
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        instruction  = 32'h0;
        instruction8 = 32'h0;
        model_reset();
        chk("reset_status", status_out, 32'h0);
        chk("reset_illegal", {31'h0, illegal}, 32'h0);
        chk("reset_status8", status_out8, 32'h0);
        chk("reset_illegal8", {31'h0, illegal8}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] exp_status;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [9];

    logic [5:0] legal_ops [17] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                   6'h08, 6'h09, 6'h0A, 6'h0B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14};

    initial begin
        logic [7:0]  cb;
        logic [31:0] ins;
        logic [5:0]  op;
        int          r1;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        instruction  = 32'h0;
        instruction8 = 32'h0;
        model_reset();

        cb = MUL_ON ? 8'd6 : 8'd5;
        vecs[0] = '{enc_i(6'h10, 1, 0, 16'h7FFF), 32'h7FFF_0100, 1'b0};
        vecs[1] = '{enc_i(6'h14, 2, 0, 16'h8000), 32'h0000_0200, 1'b0};
        vecs[2] = '{enc_r(6'h01, 3, 2, 2),        32'h0000_030D, 1'b0};
        vecs[3] = '{32'hF800_0000,                32'h0000_031D, 1'b1};
        vecs[4] = '{32'h0000_0000,                32'h0000_041D, 1'b0};
        vecs[5] = '{enc_r(6'h0B, 4, 1, 1), MUL_ON ? 32'h0001_0510 : 32'h0000_041D, !MUL_ON};
        vecs[6] = '{enc_r(6'h02, 5, 1, 3), {16'h7FFF, cb, 8'h14}, 1'b0};
        vecs[7] = '{enc_r(6'h08, 6, 2, 1), {16'hFFFF, cb + 8'd1, 8'h12}, 1'b0};
        vecs[8] = '{enc_r(6'h0A, 7, 3, 1), {16'h0001, cb + 8'd2, 8'h10}, 1'b0};

        do_reset();

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            instruction = vecs[i].ins;
            @(posedge clk);
            #1;
            model_exec(vecs[i].ins);
            chk($sformatf("vec%0d_status", i), status_out, vecs[i].exp_status);
            chk($sformatf("vec%0d_illegal", i), {31'h0, illegal}, {31'h0, vecs[i].exp_ill});
        end

        // Random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else op = legal_ops[$urandom_range(0, 16)];
            r1  = int'($urandom_range(0, 15));
            ins = {op, 4'($urandom_range(0, 15)), 4'(r1), 18'($urandom)};
            // Same-register operands make zero and equality results common
            if ($urandom_range(0, 3) == 0) ins[17:14] = 4'(r1);
            exec_chk(ins, $sformatf("rand%0d", n));
        end

        // Reset mid-stream: the ADDI r1 held during reset must not land
        do_reset();
        exec_chk(enc_r(6'h01, 2, 1, 0), "post_reset_add");
        chk("post_reset_discard", status_out, 32'h0000_0101);

        // Retired count wraps after 256 NOPs, flags untouched
        do_reset();
        for (int n = 0; n < 255; n++) exec_chk(32'h0, "nop");
        chk("nop_count_ff", status_out, 32'h0000_FF00);
        exec_chk(32'h0, "nop_last");
        chk("nop_wrap", status_out, 32'h0000_0000);

        // Eight-register instance: out-of-range indices are illegal
        do_reset();
        instruction8 = enc_i(6'h10, 15, 0, 16'h0001);
        @(posedge clk); #1;
        chk("r8_rd15_status", status_out8, 32'h0000_0010);
        chk("r8_rd15_illegal", {31'h0, illegal8}, 32'h1);
        instruction8 = enc_i(6'h10, 7, 0, 16'h0005);
        @(posedge clk); #1;
        chk("r8_addi_status", status_out8, 32'h0005_0110);
        chk("r8_addi_illegal", {31'h0, illegal8}, 32'h0);
        instruction8 = enc_r(6'h01, 1, 9, 0);
        @(posedge clk); #1;
        chk("r8_rs1_status", status_out8, 32'h0005_0110);
        chk("r8_rs1_illegal", {31'h0, illegal8}, 32'h1);
        instruction8 = enc_r(6'h01, 1, 7, 8);
        @(posedge clk); #1;
        chk("r8_rs2_illegal", {31'h0, illegal8}, 32'h1);
        instruction8 = enc_i(6'h10, 1, 7, 16'h0003) | 32'h0002_0000;
        @(posedge clk); #1;
        chk("r8_itype_rs2_status", status_out8, 32'h0008_0210);
        chk("r8_itype_rs2_illegal", {31'h0, illegal8}, 32'h0);
        instruction8 = 32'h0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
